mult_seq_controller: RTL and testbench
======================================

MULT_SEQ_CONTROLLER -- requirements
Module: mult_seq_controller

Interface
REQ-001 Parameter NUM_WORDS, default 8: operand pairs processed per run; legal range 1..2^ADDR_W.
REQ-002 Parameter ADDR_W, default 3: width of operand/result memory addresses.
REQ-003 Parameter MUL_LAT, default 2: cycles from a/b registered to product valid on p; legal range >=1.
REQ-004 clka  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  run request, sampled only in IDLE.
REQ-007 douta  in  32  operand ROM data; [31:16]=multiplicand, [15:0]=multiplier; valid one cycle after ena/addra.
REQ-008 ena  out  1  operand ROM enable.
REQ-009 addra  out  ADDR_W  operand ROM address.
REQ-010 a, b  out  16 each  registered operands to the Dadda multiplier.
REQ-011 p  in  32  multiplier product.
REQ-012 web  out  1  result RAM write enable, one cycle per word.
REQ-013 addrb  out  ADDR_W  result RAM address.
REQ-014 dinb  out  32  result RAM write data.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at end of run.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, LOAD, WAIT, STORE, DONE; internal word index idx (ADDR_W bits) and latency counter.
REQ-018 IDLE: start=1 -> FETCH with idx=0; otherwise remain; start while busy SHALL be ignored, not queued.
REQ-019 FETCH: ena=1, addra=idx for exactly one cycle -> LOAD.
REQ-020 LOAD: a<=douta[31:16], b<=douta[15:0] -> WAIT with counter loaded to MUL_LAT.
REQ-021 WAIT: SHALL last exactly MUL_LAT cycles; a, b held stable throughout.
REQ-022 STORE: web=1, addrb=idx, dinb=p for one cycle; idx==NUM_WORDS-1 -> DONE, else idx+1 -> FETCH.
REQ-023 DONE: done=1 for one cycle -> IDLE; start in DONE cycle ignored.
REQ-024 Per-word latency SHALL be MUL_LAT+3 cycles; DONE entered NUM_WORDS*(MUL_LAT+3) edges after the edge sampling start (40 with defaults).
REQ-025 ena, web, done SHALL be 0 in all states other than those listed; addra/addrb hold last value when inactive.
REQ-026 idx SHALL never exceed NUM_WORDS-1; no address wrap within a run; each run restarts at address 0.
REQ-027 a, b SHALL be zeroed on entering IDLE from DONE.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, idx=0, counter=0, and ena, addra, a, b, web, addrb, dinb, busy, done all 0.
REQ-029 Reset mid-run SHALL abort without any further web pulse; run is not resumed after deassertion.
REQ-030 First start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-031 Macro MULT_SEQ_ACC_EN defined: extra output acc (out, 32+ADDR_W bits) SHALL exist, cleared at start acceptance, acc<=acc+p in each STORE, held until next start, 0 on reset.
REQ-032 MULT_SEQ_ACC_EN undefined: acc port and adder SHALL be absent; all other behaviour identical.

Verification
REQ-033 ROM[0]=0x0003_0005, start pulse, MUL_LAT=2 -> web at addrb=0 with dinb=0x0000_000F, 5 edges after start sampled.
REQ-034 ROM[i]=0xFFFF_FFFF all i -> every dinb=0xFFFE_0001; done pulse exactly once, 40 edges after start; busy low next cycle.
REQ-035 start held high continuously -> back-to-back runs separated by exactly one IDLE cycle; no start accepted while busy.
REQ-036 rst asserted during WAIT of word 3 -> outputs 0 same cycle; no web after; restart writes addresses 0..7 again.
REQ-037 MULT_SEQ_ACC_EN, ROM[i]=(i+1)<<16 | 2 -> acc=72 at done; without macro, design compiles with no acc port.

Source files
------------

// File: rtl/mult_seq_if.sv
// mult_seq_if: signal bundle between mult_seq_controller and its operand ROM,
// Dadda multiplier and result RAM.
//   master (controller): in  start, douta[31:0], p[31:0]
//                        out ena, addra, a[15:0], b[15:0], web, addrb, dinb[31:0], busy, done
//   slave  (environment): the mirror image
//   acc[31+ADDR_W:0] (master out) exists only when MULT_SEQ_ACC_EN is defined.
interface mult_seq_if #(
    parameter int ADDR_W = 3
);
    logic              start;
    logic [31:0]       douta;
    logic              ena;
    logic [ADDR_W-1:0] addra;
    logic [15:0]       a;
    logic [15:0]       b;
    logic [31:0]       p;
    logic              web;
    logic [ADDR_W-1:0] addrb;
    logic [31:0]       dinb;
    logic              busy;
    logic              done;
`ifdef MULT_SEQ_ACC_EN
    logic [31+ADDR_W:0] acc;
`endif

    modport master (
        input  start, douta, p,
        output ena, addra, a, b, web, addrb, dinb, busy, done
`ifdef MULT_SEQ_ACC_EN
        , output acc
`endif
    );

    modport slave (
        output start, douta, p,
        input  ena, addra, a, b, web, addrb, dinb, busy, done
`ifdef MULT_SEQ_ACC_EN
        , input acc
`endif
    );
endinterface

// File: rtl/mult_seq_controller.sv
// mult_seq_controller: walks NUM_WORDS operand pairs from a ROM through a
// pipelined multiplier of latency MUL_LAT and writes each product to a RAM.
//   clka : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : mult_seq_if.master (start/douta/p in; ena/addra, a/b, web/addrb/dinb,
//          busy, done out; acc out when MULT_SEQ_ACC_EN is defined)
// Optional macro MULT_SEQ_ACC_EN adds a running sum of all products of a run.
module mult_seq_controller #(
    parameter int NUM_WORDS = 8,
    parameter int ADDR_W    = 3,
    parameter int MUL_LAT   = 2
) (
    input logic        clka,
    input logic        rst,
    mult_seq_if.master bus
);
    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, STORE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [CW-1:0]     cnt;

    wire last = idx == ADDR_W'(NUM_WORDS - 1);

    // Outputs are registered on the edge that enters a state, except the RAM
    // write: p only settles during STORE, so web/addrb/dinb are captured on the
    // edge that leaves STORE and the write strobe follows STORE by one cycle.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            bus.ena   <= 1'b0;
            bus.addra <= '0;
            bus.a     <= '0;
            bus.b     <= '0;
            bus.web   <= 1'b0;
            bus.addrb <= '0;
            bus.dinb  <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
`ifdef MULT_SEQ_ACC_EN
            bus.acc   <= '0;
`endif
        end else begin
            bus.ena  <= 1'b0;
            bus.web  <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state     <= FETCH;
                    idx       <= '0;
                    bus.ena   <= 1'b1;
                    bus.addra <= '0;
                    bus.busy  <= 1'b1;
`ifdef MULT_SEQ_ACC_EN
                    bus.acc   <= '0;
`endif
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    bus.a <= bus.douta[31:16];
                    bus.b <= bus.douta[15:0];
                    cnt   <= CW'(MUL_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= STORE;
                end
                STORE: begin
                    bus.web   <= 1'b1;
                    bus.addrb <= idx;
                    bus.dinb  <= bus.p;
`ifdef MULT_SEQ_ACC_EN
                    bus.acc   <= bus.acc + {{ADDR_W{1'b0}}, bus.p};
`endif
                    if (last) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state     <= FETCH;
                        idx       <= idx + 1'b1;
                        bus.ena   <= 1'b1;
                        bus.addra <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.a    <= '0;
                    bus.b    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_controller.sv
// tb_mult_seq_controller: directed runs with random ROM data; a ROM, a
// MUL_LAT-stage multiplier and event logs model the surroundings, and the
// expected write/done timing and data come from the per-word period rule.
module tb_mult_seq_controller;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int ML = 2;
    localparam int L  = ML + 3;

    typedef struct {
        int          c;
        logic [AW-1:0] ad;
        logic [31:0] v;
    } ev_t;

    logic clka = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   e0 = 0;

    logic [31:0] rom  [N];
    logic [31:0] pipe [ML];
    ev_t  ena_log[$];
    ev_t  wr_log[$];
    int   done_log[$];
    logic end_busy;
    logic [15:0] end_a, end_b;
    logic [63:0] acc_at_done;

    mult_seq_if #(.ADDR_W(AW)) bus ();

    mult_seq_controller #(.NUM_WORDS(N), .ADDR_W(AW), .MUL_LAT(ML)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus.master)
    );

    always #5 clka = ~clka;
    always @(posedge clka) cyc <= cyc + 1;

    always @(posedge clka) if (bus.ena) bus.douta <= rom[bus.addra];

    always @(posedge clka) begin
        pipe[0] <= {16'b0, bus.a} * {16'b0, bus.b};
        for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.p = pipe[ML-1];

    function automatic logic [31:0] prod(input logic [31:0] r);
        return 32'(r[31:16]) * 32'(r[15:0]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_ena"}, 64'(bus.ena), 0);
        chk({pfx, "_addra"}, 64'(bus.addra), 0);
        chk({pfx, "_a"}, 64'(bus.a), 0);
        chk({pfx, "_b"}, 64'(bus.b), 0);
        chk({pfx, "_web"}, 64'(bus.web), 0);
        chk({pfx, "_addrb"}, 64'(bus.addrb), 0);
        chk({pfx, "_dinb"}, 64'(bus.dinb), 0);
        chk({pfx, "_busy"}, 64'(bus.busy), 0);
        chk({pfx, "_done"}, 64'(bus.done), 0);
`ifdef MULT_SEQ_ACC_EN
        chk({pfx, "_acc"}, 64'(bus.acc), 0);
`endif
    endtask

    task automatic go(input bit hold);
        bus.start = 1'b1;
        e0 = cyc + 1;
        if (!hold) begin
            @(negedge clka);
            bus.start = 1'b0;
        end
    endtask

    // Observe one run whose start is sampled at edge s; every word occupies L
    // cycles, so fetch i shows at s+L*i, write i at s+L*(i+1), done at s+L*N.
    task automatic check_run(input int s);
        int rel;
        logic [63:0] sum;
        ena_log.delete();
        wr_log.delete();
        done_log.delete();
        sum = 0;
        for (int i = 0; i < N; i++) sum += 64'(prod(rom[i]));
        for (int k = 0; k < 400; k++) begin
            rel = cyc - s;
            if (rel >= 0 && rel <= L * N + 1) begin
                if (bus.ena) ena_log.push_back('{cyc, bus.addra, 32'h0});
                if (bus.web) wr_log.push_back('{cyc, bus.addrb, bus.dinb});
                if (bus.done) done_log.push_back(cyc);
                if (rel <= L * N) chk("busy_in_run", 64'(bus.busy), 1);
                if (rel < L * N && rel % L >= 2) begin
                    chk("a_held", 64'(bus.a), 64'(rom[rel / L][31:16]));
                    chk("b_held", 64'(bus.b), 64'(rom[rel / L][15:0]));
                end
`ifdef MULT_SEQ_ACC_EN
                if (rel == L * N) acc_at_done = 64'(bus.acc);
`endif
                if (rel == L * N + 1) begin
                    end_busy = bus.busy;
                    end_a = bus.a;
                    end_b = bus.b;
                end
            end
            if (rel >= L * N + 1) break;
            @(negedge clka);
        end
        chk("run_ended", 64'(cyc >= s + L * N + 1), 1);
        chk("ena_count", 64'(ena_log.size()), N);
        for (int i = 0; i < ena_log.size(); i++) begin
            chk("ena_cycle", 64'(ena_log[i].c - s), 64'(L * i));
            chk("addra", 64'(ena_log[i].ad), 64'(i));
        end
        chk("web_count", 64'(wr_log.size()), N);
        for (int i = 0; i < wr_log.size(); i++) begin
            chk("web_cycle", 64'(wr_log[i].c - s), 64'(L * (i + 1)));
            chk("addrb", 64'(wr_log[i].ad), 64'(i));
            chk("dinb", 64'(wr_log[i].v), 64'(prod(rom[i])));
        end
        chk("done_count", 64'(done_log.size()), 1);
        if (done_log.size() > 0) chk("done_cycle", 64'(done_log[0] - s), 64'(L * N));
        chk("busy_after_done", 64'(end_busy), 0);
        chk("a_zeroed", 64'(end_a), 0);
        chk("b_zeroed", 64'(end_b), 0);
`ifdef MULT_SEQ_ACC_EN
        chk("acc_at_done", acc_at_done, sum & ((64'd1 << (32 + AW)) - 1));
`endif
    endtask

    initial begin
        int wcount, bad;
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) rom[i] = 32'h0;
        repeat (3) @(negedge clka);
        chk_zero("reset");

        // single word example plus random remainder; start on first edge out of reset
        rom[0] = 32'h0003_0005;
        for (int i = 1; i < N; i++) rom[i] = $urandom;
        rst = 1'b0;
        go(0);
        check_run(e0);
        if (wr_log.size() > 0) begin
            chk("first_dinb", 64'(wr_log[0].v), 64'h0000_000F);
            chk("first_web_edge", 64'(wr_log[0].c - e0), 5);
        end

        // all-ones operands
        for (int i = 0; i < N; i++) rom[i] = 32'hFFFF_FFFF;
        go(0);
        check_run(e0);
        for (int i = 0; i < wr_log.size(); i++) chk("ones_dinb", 64'(wr_log[i].v), 64'hFFFE_0001);

        // start held high: two back-to-back runs one IDLE cycle apart
        for (int i = 0; i < N; i++) rom[i] = ((i + 1) << 16) | 2;
        go(1);
        check_run(e0);
`ifdef MULT_SEQ_ACC_EN
        chk("acc_72_run1", acc_at_done, 72);
`endif
        check_run(e0 + L * N + 2);
        bus.start = 1'b0;
`ifdef MULT_SEQ_ACC_EN
        chk("acc_72_run2", acc_at_done, 72);
`endif

        // reset during the WAIT of word 3, then a fresh run
        for (int i = 0; i < N; i++) rom[i] = $urandom;
        go(0);
        wcount = 0;
        while (cyc < e0 + 3 * L + 2) begin
            if (bus.web) wcount++;
            @(negedge clka);
        end
        chk("writes_before_rst", 64'(wcount), 3);
        rst = 1'b1;
        #1;
        chk_zero("midrun_rst");
        repeat (2) @(negedge clka);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clka);
            if (bus.web || bus.ena || bus.busy) bad++;
        end
        chk("quiet_after_rst", 64'(bad), 0);
        for (int i = 0; i < N; i++) rom[i] = $urandom;
        go(0);
        check_run(e0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
